// File: rtl/btn_debounce_edge.sv
// Multi-channel button debouncer: 2-flop synchronizer plus a per-channel
// ZERO/WAIT1/ONE/WAIT0 filter clocked by an external tick strobe.
module btn_debounce_edge #(
   parameter int N_BTN        = 4,
   parameter int STABLE_TICKS = 4,
   parameter bit ACTIVE_LOW   = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tick,
   input  logic [N_BTN-1:0] btn_raw,
   output logic             timer_en,
   output logic [N_BTN-1:0] db_level,
   output logic [N_BTN-1:0] db_rise,
   output logic [N_BTN-1:0] db_fall
);

   localparam int               CNT_W    = $clog2(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [N_BTN-1:0] RAW_INV  = ACTIVE_LOW ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

   typedef enum logic [1:0] {
      ST_ZERO  = 2'd0,
      ST_WAIT1 = 2'd1,
      ST_ONE   = 2'd2,
      ST_WAIT0 = 2'd3
   } state_e;

   logic [N_BTN-1:0] sync1_q;
   logic [N_BTN-1:0] sync2_q;
   state_e           state_q [N_BTN];
   state_e           state_d [N_BTN];
   logic [CNT_W-1:0] cnt_q   [N_BTN];
   logic [CNT_W-1:0] cnt_d   [N_BTN];
   logic [N_BTN-1:0] level_q, level_d;
   logic [N_BTN-1:0] rise_q, rise_d;
   logic [N_BTN-1:0] fall_q, fall_d;
   logic [N_BTN-1:0] wait_s;

   // Two-stage synchronizer on the polarity-corrected raw inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= {N_BTN{1'b0}};
         sync2_q <= {N_BTN{1'b0}};
      end else begin
         sync1_q <= btn_raw ^ RAW_INV;
         sync2_q <= sync1_q;
      end
   end

   // Per-channel next state; a mismatch always takes priority over a tick.
   always_comb begin
      for (int i = 0; i < N_BTN; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         rise_d[i]  = 1'b0;
         fall_d[i]  = 1'b0;
         case (state_q[i])
            ST_ZERO: begin
               if (sync2_q[i]) begin
                  state_d[i] = ST_WAIT1;
                  cnt_d[i]   = CNT_ZERO;
               end else begin
                  state_d[i] = ST_ZERO;
               end
            end
            ST_WAIT1: begin
               if (!sync2_q[i]) begin
                  state_d[i] = ST_ZERO;
                  cnt_d[i]   = CNT_ZERO;
               end else if (tick && (cnt_q[i] == CNT_LAST)) begin
                  state_d[i] = ST_ONE;
                  rise_d[i]  = 1'b1;
               end else if (tick) begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end else begin
                  cnt_d[i] = cnt_q[i];
               end
            end
            ST_ONE: begin
               if (!sync2_q[i]) begin
                  state_d[i] = ST_WAIT0;
                  cnt_d[i]   = CNT_ZERO;
               end else begin
                  state_d[i] = ST_ONE;
               end
            end
            ST_WAIT0: begin
               if (sync2_q[i]) begin
                  state_d[i] = ST_ONE;
                  cnt_d[i]   = CNT_ZERO;
               end else if (tick && (cnt_q[i] == CNT_LAST)) begin
                  state_d[i] = ST_ZERO;
                  fall_d[i]  = 1'b1;
               end else if (tick) begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end else begin
                  cnt_d[i] = cnt_q[i];
               end
            end
            default: begin
               state_d[i] = ST_ZERO;
               cnt_d[i]   = CNT_ZERO;
            end
         endcase
         level_d[i] = (state_d[i] == ST_ONE) || (state_d[i] == ST_WAIT0);
         wait_s[i]  = (state_q[i] == ST_WAIT1) || (state_q[i] == ST_WAIT0);
      end
   end

   // State, counters and registered outputs all update on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_BTN; i++) begin
            state_q[i] <= ST_ZERO;
            cnt_q[i]   <= CNT_ZERO;
         end
         level_q <= {N_BTN{1'b0}};
         rise_q  <= {N_BTN{1'b0}};
         fall_q  <= {N_BTN{1'b0}};
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign timer_en = |wait_s;
   assign db_level = level_q;
   assign db_rise  = rise_q;
   assign db_fall  = fall_q;

endmodule

// File: tb/tb_btn_debounce_edge.sv
// Bench for btn_debounce_edge: cycle scoreboard on the default instance plus
// directed sequences for STABLE_TICKS=1 and ACTIVE_LOW=1 instances.
module tb_btn_debounce_edge;

   logic       clk;
   logic       reset_n, rst1_n;
   logic       tick, tick1;
   logic [3:0] btn_raw, raw1, raw2;
   logic       timer_en, ten1, ten2;
   logic [3:0] lvl, rise, fall;
   logic [3:0] lvl1, rise1, fall1;
   logic [3:0] lvl2, rise2, fall2;

   btn_debounce_edge #(.N_BTN(4), .STABLE_TICKS(4), .ACTIVE_LOW(1'b0)) u_dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .btn_raw(btn_raw),
      .timer_en(timer_en), .db_level(lvl), .db_rise(rise), .db_fall(fall));

   btn_debounce_edge #(.N_BTN(4), .STABLE_TICKS(1), .ACTIVE_LOW(1'b0)) u_dut_st1 (
      .clk(clk), .reset_n(rst1_n), .tick(tick1), .btn_raw(raw1),
      .timer_en(ten1), .db_level(lvl1), .db_rise(rise1), .db_fall(fall1));

   btn_debounce_edge #(.N_BTN(4), .STABLE_TICKS(4), .ACTIVE_LOW(1'b1)) u_dut_al (
      .clk(clk), .reset_n(reset_n), .tick(tick), .btn_raw(raw2),
      .timer_en(ten2), .db_level(lvl2), .db_rise(rise2), .db_fall(fall2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] lvl;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       ten;
   } exp_t;

   typedef struct {
      logic [3:0] raw;
      int         hold;
      logic [3:0] exp_lvl;
      int         exp_rise;
      int         exp_fall;
   } vec_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   int   rise_acc = 0;
   int   fall_acc = 0;
   bit   auto_tick;
   int   tcnt;

   // Reference model state for the default instance (0 ZERO,1 WAIT1,2 ONE,3 WAIT0).
   bit   m_s1 [4];
   bit   m_s2 [4];
   int   m_st [4];
   int   m_rem[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
      end
   endtask

   // Debounce modelled as "ticks remaining" countdown from entry into a wait.
   task automatic model_step(output exp_t e);
      bit s;
      e.lvl = 4'h0; e.rise = 4'h0; e.fall = 4'h0; e.ten = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!reset_n) begin
            m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_st[i] = 0; m_rem[i] = 0;
         end else begin
            s = m_s2[i];
            case (m_st[i])
               0: if (s) begin m_st[i] = 1; m_rem[i] = 4; end
               1: if (!s) m_st[i] = 0;
                  else if (tick) begin
                     m_rem[i]--;
                     if (m_rem[i] == 0) begin m_st[i] = 2; e.rise[i] = 1'b1; end
                  end
               2: if (!s) begin m_st[i] = 3; m_rem[i] = 4; end
               default: if (s) m_st[i] = 2;
                  else if (tick) begin
                     m_rem[i]--;
                     if (m_rem[i] == 0) begin m_st[i] = 0; e.fall[i] = 1'b1; end
                  end
            endcase
            m_s2[i] = m_s1[i];
            m_s1[i] = btn_raw[i];
         end
         e.lvl[i] = (m_st[i] == 2) || (m_st[i] == 3);
         if (m_st[i] == 1 || m_st[i] == 3) e.ten = 1'b1;
      end
   endtask

   task automatic cycle();
      exp_t e;
      if (auto_tick) begin
         tick = (tcnt == 9);
         tcnt = (tcnt + 1) % 10;
      end
      model_step(e);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("sb_level", lvl, e.lvl);
      chk("sb_rise", rise, e.rise);
      chk("sb_fall", fall, e.fall);
      chk("sb_timer_en", timer_en, e.ten);
      rise_acc += $countones(rise);
      fall_acc += $countones(fall);
   endtask

   vec_t vecs[9];

   initial begin
      int first, nr, np;
      logic [3:0] pv;

      vecs[0] = '{4'b0000, 60, 4'b0000, 0, 4};
      vecs[1] = '{4'b0001, 60, 4'b0001, 1, 0};
      vecs[2] = '{4'b0011, 60, 4'b0011, 1, 0};
      vecs[3] = '{4'b1100, 60, 4'b1100, 2, 2};
      vecs[4] = '{4'b0000, 60, 4'b0000, 0, 2};
      vecs[5] = '{4'b1111, 60, 4'b1111, 4, 0};
      vecs[6] = '{4'b0000, 20, 4'b1111, 0, 0};
      vecs[7] = '{4'b1111, 60, 4'b1111, 0, 0};
      vecs[8] = '{4'b0000, 60, 4'b0000, 0, 4};

      reset_n = 1'b0; rst1_n = 1'b0;
      tick = 1'b0; tick1 = 1'b1;
      btn_raw = 4'hF; raw1 = 4'h0; raw2 = 4'hF;
      auto_tick = 1'b1; tcnt = 0;
      for (int i = 0; i < 4; i++) begin
         m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_st[i] = 0; m_rem[i] = 0;
      end

      // Reset held with buttons pressed.
      repeat (5) cycle();
      chk("rst_level", lvl, 4'h0);
      chk("rst_rise", rise, 4'h0);
      chk("rst_fall", fall, 4'h0);
      chk("rst_timer_en", timer_en, 1'b0);

      // Release: held buttons re-debounce from scratch.
      reset_n = 1'b1; rst1_n = 1'b1; tcnt = 0;
      first = -1; nr = 0;
      for (int n = 1; n <= 60; n++) begin
         cycle();
         if (rise[0]) begin
            nr++;
            if (first < 0) first = n;
         end
      end
      chk("rel_rise_count", nr, 1);
      chk("rel_rise_window", (first >= 31 && first <= 41), 1);
      chk("rel_level0", lvl[0], 1'b1);

      // Table of held input patterns.
      for (int v = 0; v < 9; v++) begin
         btn_raw = vecs[v].raw;
         rise_acc = 0; fall_acc = 0;
         repeat (vecs[v].hold) cycle();
         chk("vec_level", lvl, vecs[v].exp_lvl);
         chk("vec_rises", rise_acc, vecs[v].exp_rise);
         chk("vec_falls", fall_acc, vecs[v].exp_fall);
      end

      // Bounce on channel 1, then a clean hold.
      rise_acc = 0; fall_acc = 0;
      for (int k = 0; k < 14; k++) begin
         btn_raw = (k % 2 == 0) ? 4'b0010 : 4'b0000;
         repeat (7) cycle();
      end
      chk("bounce_no_rise", rise_acc, 0);
      chk("bounce_no_fall", fall_acc, 0);
      btn_raw = 4'b0010; rise_acc = 0;
      repeat (60) cycle();
      chk("bounce_one_rise", rise_acc, 1);
      chk("bounce_level", lvl, 4'b0010);
      btn_raw = 4'b0000; fall_acc = 0;
      repeat (60) cycle();
      chk("bounce_one_fall", fall_acc, 1);

      // Mismatch coinciding with the final tick on channel 2.
      auto_tick = 1'b0; tick = 1'b0;
      btn_raw = 4'b0100;
      repeat (3) cycle();
      chk("coll_wait_entry", timer_en, 1'b1);
      rise_acc = 0;
      for (int k = 0; k < 3; k++) begin
         tick = 1'b1; cycle();
         tick = 1'b0; cycle();
      end
      btn_raw = 4'b0000;
      cycle();
      cycle();
      tick = 1'b1; cycle();
      tick = 1'b0;
      chk("coll_no_rise", rise[2], 1'b0);
      chk("coll_level", lvl[2], 1'b0);
      chk("coll_timer_off", timer_en, 1'b0);
      repeat (10) cycle();
      chk("coll_rises_total", rise_acc, 0);
      auto_tick = 1'b1; tcnt = 0;

      // ACTIVE_LOW instance: all four pressed together.
      chk("al_idle_level", lvl2, 4'h0);
      raw2 = 4'h0; np = 0; pv = 4'h0;
      for (int n = 0; n < 60; n++) begin
         cycle();
         if (rise2 != 4'h0) begin
            np++;
            pv = rise2;
         end
      end
      chk("al_rise_pulses", np, 1);
      chk("al_rise_value", pv, 4'hF);
      chk("al_level", lvl2, 4'hF);

      // STABLE_TICKS=1 instance with a tick every clock.
      raw1 = 4'b0001;
      for (int k = 1; k <= 4; k++) begin
         cycle();
         chk("st1_rise_timing", rise1[0], (k == 4) ? 1'b1 : 1'b0);
      end
      chk("st1_level", lvl1[0], 1'b1);
      cycle();
      chk("st1_single_pulse", rise1[0], 1'b0);
      raw1 = 4'b0000;
      repeat (3) cycle();
      chk("st1_in_wait0", ten1, 1'b1);
      chk("st1_wait0_level", lvl1[0], 1'b1);
      rst1_n = 1'b0;
      #1;
      chk("st1_rst_level", lvl1, 4'h0);
      chk("st1_rst_timer_en", ten1, 1'b0);
      chk("st1_rst_edges", {rise1, fall1}, 8'h00);
      raw1 = 4'b0001;
      repeat (2) cycle();
      chk("st1_rst_hold_rise", rise1, 4'h0);
      rst1_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         cycle();
         chk("st1_restart_rise", rise1[0], (k == 4) ? 1'b1 : 1'b0);
      end
      chk("st1_restart_level", lvl1[0], 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/btn_debounce_edge.md
# btn_debounce_edge

Multi-channel button debouncer and edge detector. It sits directly downstream of the team's parameterized tick timer and consumes that timer's one-cycle `done` pulse as its sampling `tick`. Each raw button is synchronized and then filtered by a per-channel state machine, which requires the input to be stable for `STABLE_TICKS` ticks. Each channel outputs a clean level plus one-cycle rise and fall pulses for downstream control logic.

## Interface
- `N_BTN`, 4: number of independent button channels (≥1).
- `STABLE_TICKS`, 4: number of ticks an input must stay stable before the debounced level changes (≥1).
- `ACTIVE_LOW`, 0: when 1, raw inputs are inverted before synchronization (pressed = raw 0).

- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  one-`clk`-wide sampling strobe (timer `done`). Any period ≥ 1 clk.
- `btn_raw`  in  `N_BTN`  asynchronous raw button inputs.
- `timer_en`  out  1  high while any channel is in a WAIT state. Drives the upstream timer `enable`.
- `db_level`  out  `N_BTN`  debounced level, 1 = pressed.
- `db_rise`  out  `N_BTN`  one-clk pulse on each debounced 0→1 transition.
- `db_fall`  out  `N_BTN`  one-clk pulse on each debounced 1→0 transition.

## Operation
**Synchronizer**
- Each channel has a 2-flop synchronizer on `btn_raw ^ ACTIVE_LOW`, reset to 0. Its output is `s[i]`.

**Per-channel FSM**
- States: ZERO, WAIT1, ONE, WAIT0.
- Each channel has a counter `cnt` of width `$clog2(STABLE_TICKS+1)`, reset to 0.
- ZERO:
  - `s`=1 → WAIT1, `cnt`←0.
  - Otherwise stay.
- WAIT1:
  - `s`=0 → ZERO, `cnt`←0.
  - Else if `tick` and `cnt`==`STABLE_TICKS`-1 → ONE.
  - Else if `tick` → `cnt`+1.
- ONE:
  - `s`=0 → WAIT0, `cnt`←0.
  - Otherwise stay.
- WAIT0: mirror of WAIT1 with the polarity swapped. It exits to ONE on `s`=1 and to ZERO on the final tick.

**Outputs**
- `db_level[i]` is registered. It is 1 exactly while the state is ONE or WAIT0.
- `db_rise[i]` is registered and high for exactly the one cycle in which `db_level[i]` first reads 1 (WAIT1→ONE transition).
- `db_fall[i]` is the same for the WAIT0→ZERO transition.
- `db_rise[i]` and `db_fall[i]` are never both high.
- `timer_en` is combinational: the OR over channels of (state ∈ {WAIT1, WAIT0}).

**Boundary conditions**
- Input mismatch and `tick` in the same cycle: the mismatch wins. The state returns and `cnt` does not advance.
- `STABLE_TICKS`=1: the first tick seen in WAIT completes the debounce.
- `cnt` never exceeds `STABLE_TICKS`-1, so there is no wrap-around.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulses in the same cycle.
- `reset_n` low at any time, including mid-WAIT:
  - All states go to ZERO and all counters and synchronizers clear.
  - `db_level`, `db_rise`, `db_fall` and `timer_en` are all 0.
  - After release, a channel held pressed re-debounces from scratch. No `db_rise` is emitted during reset.

## Timing
- Raw change to `s` change: 2 clk.
- `s` change to WAIT entry: 1 clk.
- WAIT entry to ONE/ZERO: the clock edge of the `STABLE_TICKS`-th tick. Because tick phase is unaligned, the debounce interval is between `STABLE_TICKS`-1 and `STABLE_TICKS` tick periods, plus the above.
- `db_level`, `db_rise` and `db_fall` change on the same edge as the state change, so edge pulses have 0 extra latency versus `db_level`.
- A `tick` arriving while in ZERO or ONE is ignored.

## Test plan
All scenarios use `N_BTN`=4, `STABLE_TICKS`=4, and `tick` every 10 clk unless stated.

- **Reset values:** hold `reset_n`=0 with `btn_raw`=4'hF → all outputs 0 and `timer_en`=0. Release → `db_level[0]` rises with a single `db_rise[0]` pulse after 4 ticks (31–41 clk).
- **Clean press and release, ch0:** 0→1 → `timer_en` high, `db_rise[0]` 1 clk on the 4th tick, `db_level[0]`=1. Release 1→0 → `db_fall[0]` 1 clk on the 4th tick after WAIT0 entry.
- **Bounce:** toggle `btn_raw[1]` every 7 clk for 100 clk, then hold 1 → no pulses during bouncing, exactly one `db_rise[1]`. `cnt` restarts on each toggle.
- **Tick/mismatch collision:** `s` drops in the same cycle as the 4th tick while in WAIT1 → state returns to ZERO, no `db_rise`, `db_level` stays 0.
- **`STABLE_TICKS`=1, tick every clk:** press → `db_rise` exactly 4 clk after the raw change. Mid-WAIT `reset_n` pulse → outputs 0 and debounce restarts.
- **`ACTIVE_LOW`=1:** all four channels pressed simultaneously (raw 4'hF→4'h0) → `db_rise`=4'hF in a single cycle, `db_level`=4'hF.
